// File: rtl/dp_res_accumulator.sv
// dp_res_accumulator: captures signed result vectors from DP0/DP1, optionally sums DP0+DP1,
//    accumulates partial sums in indexed slots and serializes finished vectors one word per beat.
// Latency: capture in cycle N -> words N+1..N+NUM_RES at full rate, done_o in N+NUM_RES+1.
// Backpressure: out_ready_i low holds the current word; both engine readies stay low while emitting.
// Ports: clk_i/rst_ni/clear_i control; per engine dpX_valid_i/dpX_ready_o/dpX_res_i/
//    dpX_to_buffer_i/dpX_buf_idx_i; add_enable_i mode; out_valid_o/out_ready_i/out_data_o; done_o.
module dp_res_accumulator #(
   parameter int NUM_RES   = 4,
   parameter int RES_W     = 16,
   parameter int BUF_DEPTH = 2,
   parameter int ACC_W     = 32,
   parameter int IDX_W     = $clog2(BUF_DEPTH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     add_enable_i,
   input  logic                     dp0_valid_i,
   output logic                     dp0_ready_o,
   input  logic [NUM_RES*RES_W-1:0] dp0_res_i,
   input  logic                     dp0_to_buffer_i,
   input  logic [IDX_W-1:0]         dp0_buf_idx_i,
   input  logic                     dp1_valid_i,
   output logic                     dp1_ready_o,
   input  logic [NUM_RES*RES_W-1:0] dp1_res_i,
   input  logic                     dp1_to_buffer_i,
   input  logic [IDX_W-1:0]         dp1_buf_idx_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [ACC_W-1:0]         out_data_o,
   output logic                     done_o
);

   localparam int CNT_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_RES - 1);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
   typedef logic [NUM_RES-1:0][ACC_W-1:0] vec_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    rr_q, rr_d;        // 0: DP0 wins the next tie, 1: DP1
   logic                    done_q, done_d;
   logic [BUF_DEPTH-1:0]    occ_q, occ_d;
   vec_t [BUF_DEPTH-1:0]    acc_buf_q, acc_buf_d;
   vec_t                    ovec_q, ovec_d;

   logic                    grant0, grant1, both, cap, cap_to_buf;
   logic [IDX_W-1:0]        cap_idx;
   logic [NUM_RES*RES_W-1:0] prim_res;
   vec_t                    base_vec, sum_vec;

   // Grant logic: nothing is accepted while emitting or while a clear is pending.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE && !clear_i) begin
         if (add_enable_i) begin
            // Add mode consumes both vectors in the same cycle or neither.
            grant0 = dp0_valid_i & dp1_valid_i;
            grant1 = dp0_valid_i & dp1_valid_i;
         end else begin
            grant0 = dp0_valid_i & (!dp1_valid_i | !rr_q);
            grant1 = dp1_valid_i & (!dp0_valid_i | rr_q);
         end
      end
   end

   // Capture datapath: element-wise sign-extended sum plus the slot's partial sum if occupied.
   always_comb begin
      both = grant0 & grant1;
      cap  = grant0 | grant1;
      // DP1 routing fields only matter when DP1 is captured on its own.
      if (grant1 && !grant0) begin
         prim_res   = dp1_res_i;
         cap_idx    = dp1_buf_idx_i;
         cap_to_buf = dp1_to_buffer_i;
      end else begin
         prim_res   = dp0_res_i;
         cap_idx    = dp0_buf_idx_i;
         cap_to_buf = dp0_to_buffer_i;
      end
      base_vec = occ_q[cap_idx] ? acc_buf_q[cap_idx] : '0;
      sum_vec  = '0;
      for (int k = 0; k < NUM_RES; k++) begin
         sum_vec[k] = ACC_W'($signed(prim_res[k*RES_W +: RES_W])) + base_vec[k];
         if (both) begin
            sum_vec[k] = sum_vec[k] + ACC_W'($signed(dp1_res_i[k*RES_W +: RES_W]));
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_d      = rr_q;
      done_d    = 1'b0;
      occ_d     = occ_q;
      acc_buf_d = acc_buf_q;
      ovec_d    = ovec_q;
      if (clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         rr_d      = 1'b0;
         occ_d     = '0;
         acc_buf_d = '0;
         ovec_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cap) begin
                  // After a single grant the other port gets priority on the next tie.
                  if (!both) begin
                     rr_d = grant0;
                  end
                  if (cap_to_buf) begin
                     acc_buf_d[cap_idx] = sum_vec;
                     occ_d[cap_idx]     = 1'b1;
                  end else begin
                     ovec_d         = sum_vec;
                     occ_d[cap_idx] = 1'b0;
                     cnt_d          = '0;
                     state_d        = EMIT;
                  end
               end
            end
            EMIT: begin
               if (out_ready_i) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_q      <= 1'b0;
         done_q    <= 1'b0;
         occ_q     <= '0;
         acc_buf_q <= '0;
         ovec_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         done_q    <= done_d;
         occ_q     <= occ_d;
         acc_buf_q <= acc_buf_d;
         ovec_q    <= ovec_d;
      end
   end

   assign dp0_ready_o = grant0;
   assign dp1_ready_o = grant1;
   assign out_valid_o = (state_q == EMIT);
   assign out_data_o  = out_valid_o ? ovec_q[cnt_q] : '0;
   assign done_o      = done_q;

endmodule

// File: tb/tb_dp_res_accumulator.sv
module tb_dp_res_accumulator;

   localparam int NUM_RES   = 4;
   localparam int RES_W     = 16;
   localparam int BUF_DEPTH = 2;
   localparam int ACC_W     = 32;
   localparam int IDX_W     = 1;
   localparam int VW        = NUM_RES * RES_W;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             clear_i;
   logic             add_enable_i;
   logic             dp0_valid_i, dp1_valid_i;
   logic             dp0_ready_o, dp1_ready_o;
   logic [VW-1:0]    dp0_res_i, dp1_res_i;
   logic             dp0_to_buffer_i, dp1_to_buffer_i;
   logic [IDX_W-1:0] dp0_buf_idx_i, dp1_buf_idx_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [ACC_W-1:0] out_data_o;
   logic             done_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ACC_W-1:0] exp_q[$];
   logic [ACC_W-1:0] m_buf[BUF_DEPTH][NUM_RES];
   bit               m_occ[BUF_DEPTH];
   bit               m_rr;

   dp_res_accumulator #(
      .NUM_RES(NUM_RES), .RES_W(RES_W), .BUF_DEPTH(BUF_DEPTH), .ACC_W(ACC_W), .IDX_W(IDX_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .add_enable_i(add_enable_i),
      .dp0_valid_i(dp0_valid_i), .dp0_ready_o(dp0_ready_o), .dp0_res_i(dp0_res_i),
      .dp0_to_buffer_i(dp0_to_buffer_i), .dp0_buf_idx_i(dp0_buf_idx_i),
      .dp1_valid_i(dp1_valid_i), .dp1_ready_o(dp1_ready_o), .dp1_res_i(dp1_res_i),
      .dp1_to_buffer_i(dp1_to_buffer_i), .dp1_buf_idx_i(dp1_buf_idx_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   // Scoreboard consumer: every accepted output word is compared with the oldest expectation.
   always @(negedge clk) begin : monitor
      logic [ACC_W-1:0] e;
      if (rst_ni && !clear_i && out_valid_o && out_ready_i) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_word: got %h, no word expected", out_data_o);
         end else begin
            e = exp_q.pop_front();
            if (out_data_o !== e) begin
               n_fail++;
               $display("FAIL out_word: got %h expected %h", out_data_o, e);
            end
         end
      end
   end

   function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BUF_DEPTH; i++) begin
         m_occ[i] = 1'b0;
         for (int k = 0; k < NUM_RES; k++) m_buf[i][k] = '0;
      end
      m_rr = 1'b0;
   endtask

   // Reference behaviour of one capture: stores a partial sum or pushes the finished words.
   task automatic model_cap(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit addb,
                            input bit tob, input int idx);
      logic signed [RES_W-1:0] ea, eb;
      logic [ACC_W-1:0] s;
      for (int k = 0; k < NUM_RES; k++) begin
         ea = a[k*RES_W +: RES_W];
         eb = b[k*RES_W +: RES_W];
         s  = {{(ACC_W-RES_W){ea[RES_W-1]}}, ea};
         if (addb) s = s + {{(ACC_W-RES_W){eb[RES_W-1]}}, eb};
         if (m_occ[idx]) s = s + m_buf[idx][k];
         if (tob) m_buf[idx][k] = s;
         else exp_q.push_back(s);
      end
      m_occ[idx] = tob;
   endtask

   // Offer one DP0 vector and hold it until it is accepted.
   task automatic send0(input logic [VW-1:0] a, input bit tob, input int idx);
      bit got;
      got = 1'b0;
      dp0_res_i       = a;
      dp0_to_buffer_i = tob;
      dp0_buf_idx_i   = IDX_W'(idx);
      dp0_valid_i     = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (dp0_ready_o) got = 1'b1;
         else @(posedge clk);
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL send0_grant: dp0_ready_o=%b, required 1 within 40 cycles", dp0_ready_o);
      end else begin
         @(posedge clk);
         model_cap(a, '0, 1'b0, tob, idx);
         m_rr = 1'b1;
      end
      #1 dp0_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_done: done_o=%b, required pulse within 60 cycles", tag, done_o);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; clear_i = 1'b0; add_enable_i = 1'b0; out_ready_i = 1'b0;
      dp0_valid_i = 1'b0; dp1_valid_i = 1'b0; dp0_res_i = '0; dp1_res_i = '0;
      dp0_to_buffer_i = 1'b0; dp1_to_buffer_i = 1'b0; dp0_buf_idx_i = '0; dp1_buf_idx_i = '0;
      model_reset();
      #22;
      n_checks++;
      if ({out_valid_o, done_o} !== 2'b00 || out_data_o !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b done=%b data=%h, required 0 0 0",
                  out_valid_o, done_o, out_data_o);
      end
      @(posedge clk); #1 rst_ni = 1'b1;
      #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle_ready: rdy=%b%b, required 00", dp0_ready_o, dp1_ready_o);
      end
      dp0_valid_i = 1'b1; dp1_valid_i = 1'b1; #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_rr_dp0: rdy=%b%b, required 10", dp0_ready_o, dp1_ready_o);
      end
      dp0_valid_i = 1'b0; #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_dp1_alone: rdy=%b%b, required 01", dp0_ready_o, dp1_ready_o);
      end
      dp1_valid_i = 1'b0;
   endtask

   task automatic test_single_emit();
      out_ready_i = 1'b1;
      send0(pk(1, -2, 3, -4), 1'b0, 0);
      for (int i = 0; i < NUM_RES; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat%0d_valid: out_valid_o=%b, required 1", i, out_valid_o);
         end
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b valid=%b, required 1 0", done_o, out_valid_o);
      end
      @(negedge clk);
      n_checks++;
      if (done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_pulse: done_o=%b, required 0", done_o);
      end
   endtask

   task automatic test_accumulate();
      send0(pk(10, 10, 10, 10), 1'b1, 1);
      send0(pk(5, 6, 7, 8), 1'b1, 1);
      send0(pk(1, 1, 1, 1), 1'b0, 1);
      wait_done("acc_first");
      send0(pk(1, 1, 1, 1), 1'b0, 1);
      wait_done("acc_second");
   endtask

   task automatic test_add_mode();
      @(posedge clk); #1;
      add_enable_i = 1'b1;
      dp0_res_i = pk(100, 100, 100, 100); dp0_to_buffer_i = 1'b0; dp0_buf_idx_i = 1'b0;
      dp1_res_i = pk(-30, -30, -30, -30); dp1_to_buffer_i = 1'b1; dp1_buf_idx_i = 1'b1;
      dp0_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({dp0_ready_o, dp1_ready_o, out_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL add_lone_dp0_c%0d: rdy=%b%b valid=%b, required 000",
                     i, dp0_ready_o, dp1_ready_o, out_valid_o);
         end
         @(posedge clk); #1;
      end
      dp1_valid_i = 1'b1; #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL add_both_ready: rdy=%b%b, required 11", dp0_ready_o, dp1_ready_o);
      end
      @(posedge clk);
      model_cap(dp0_res_i, dp1_res_i, 1'b1, 1'b0, 0);
      #1 dp0_valid_i = 1'b0; dp1_valid_i = 1'b0; add_enable_i = 1'b0;
      wait_done("add");
   endtask

   task automatic test_arbitration();
      bit e1;
      @(posedge clk); #1;
      dp0_res_i = pk(1, 2, 3, 4);       dp0_to_buffer_i = 1'b1; dp0_buf_idx_i = 1'b0;
      dp1_res_i = pk(1000, -1, 0, 7);   dp1_to_buffer_i = 1'b1; dp1_buf_idx_i = 1'b1;
      dp0_valid_i = 1'b1; dp1_valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         e1 = m_rr;
         n_checks++;
         if (dp0_ready_o !== !e1 || dp1_ready_o !== e1) begin
            n_fail++;
            $display("FAIL arb_grant%0d: rdy=%b%b, required %b%b",
                     i, dp0_ready_o, dp1_ready_o, !e1, e1);
         end
         @(posedge clk);
         if (e1) model_cap(dp1_res_i, '0, 1'b0, 1'b1, 1);
         else model_cap(dp0_res_i, '0, 1'b0, 1'b1, 0);
         m_rr = !e1;
      end
      #1 dp0_valid_i = 1'b0; dp1_valid_i = 1'b0;
      send0(pk(0, 0, 0, 0), 1'b0, 0);
      wait_done("arb_slot0");
      send0(pk(0, 0, 0, 0), 1'b0, 1);
      wait_done("arb_slot1");
   endtask

   task automatic test_backpressure();
      logic [7:0]       pat;
      bit               prev_stall, seen_idle;
      logic [ACC_W-1:0] prev_data;
      pat = 8'b0110_1001;
      prev_stall = 1'b0; seen_idle = 1'b0; prev_data = '0;
      out_ready_i = 1'b0;
      send0(pk(7, -8, 9, -10), 1'b0, 0);
      dp1_res_i = pk(2, 2, 2, 2); dp1_to_buffer_i = 1'b1; dp1_buf_idx_i = 1'b1;
      dp1_valid_i = 1'b1;
      for (int i = 0; i < 40 && !seen_idle; i++) begin
         out_ready_i = pat[i % 8];
         @(negedge clk);
         if (out_valid_o) begin
            n_checks++;
            if ({dp0_ready_o, dp1_ready_o} !== 2'b00) begin
               n_fail++;
               $display("FAIL bp_ready_low: rdy=%b%b, required 00", dp0_ready_o, dp1_ready_o);
            end
            if (prev_stall) begin
               n_checks++;
               if (out_data_o !== prev_data) begin
                  n_fail++;
                  $display("FAIL bp_hold: got %h required %h", out_data_o, prev_data);
               end
            end
            prev_stall = !out_ready_i;
            prev_data  = out_data_o;
         end else begin
            seen_idle = 1'b1;
            n_checks++;
            if (done_o !== 1'b1 || dp1_ready_o !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_end: done=%b dp1_rdy=%b, required 1 1", done_o, dp1_ready_o);
            end
         end
         @(posedge clk);
         if (seen_idle) begin
            model_cap(dp1_res_i, '0, 1'b0, 1'b1, 1);
            m_rr = 1'b0;
         end
         #1;
      end
      dp1_valid_i = 1'b0;
      out_ready_i = 1'b1;
      n_checks++;
      if (!seen_idle) begin
         n_fail++;
         $display("FAIL bp_finish: out_valid_o=%b, required drop within 40 cycles", out_valid_o);
      end
      send0(pk(0, 0, 0, 0), 1'b0, 1);
      wait_done("bp_slot1");
   endtask

   task automatic test_clear_mid_emit();
      out_ready_i = 1'b1;
      send0(pk(5, 5, 5, 5), 1'b1, 0);
      send0(pk(1, 2, 3, 4), 1'b0, 1);
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      clear_i = 1'b1; out_ready_i = 1'b0;
      dp0_res_i = pk(9, 9, 9, 9); dp0_to_buffer_i = 1'b0; dp0_buf_idx_i = 1'b0;
      dp0_valid_i = 1'b1; #1;
      n_checks++;
      if (dp0_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_no_capture: dp0_ready_o=%b, required 0", dp0_ready_o);
      end
      @(posedge clk); #1;
      clear_i = 1'b0; dp0_valid_i = 1'b0; #1;
      n_checks++;
      if (out_valid_o !== 1'b0 || out_data_o !== '0) begin
         n_fail++;
         $display("FAIL clr_valid_drop: valid=%b data=%h, required 0 0", out_valid_o, out_data_o);
      end
      n_checks++;
      if (exp_q.size() != 2) begin
         n_fail++;
         $display("FAIL clr_words_before: %0d words pending, required 2", exp_q.size());
      end
      exp_q.delete();
      model_reset();
      dp0_valid_i = 1'b1; dp1_valid_i = 1'b1; #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL clr_rr_dp0: rdy=%b%b, required 10", dp0_ready_o, dp1_ready_o);
      end
      dp0_valid_i = 1'b0; dp1_valid_i = 1'b0;
      out_ready_i = 1'b1;
      send0(pk(3, 3, 3, 3), 1'b0, 0);
      wait_done("clr_after");
   endtask

   task automatic test_reset_mid_emit();
      send0(pk(5, 5, 5, 5), 1'b1, 0);
      send0(pk(1, 1, 1, 1), 1'b0, 1);
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      rst_ni = 1'b0; #1;
      n_checks++;
      if ({out_valid_o, done_o} !== 2'b00 || out_data_o !== '0) begin
         n_fail++;
         $display("FAIL rst_async: valid=%b done=%b data=%h, required 0 0 0",
                  out_valid_o, done_o, out_data_o);
      end
      exp_q.delete();
      model_reset();
      @(posedge clk); #1 rst_ni = 1'b1;
      send0(pk(4, 4, 4, 4), 1'b0, 0);
      wait_done("rst_after");
   endtask

   task automatic test_wrap();
      @(posedge clk); #1;
      add_enable_i = 1'b1;
      dp0_res_i = pk(32767, 32767, 32767, -32768); dp0_to_buffer_i = 1'b1; dp0_buf_idx_i = 1'b0;
      dp1_res_i = pk(32767, 32767, 32767, -32768);
      dp0_valid_i = 1'b1; dp1_valid_i = 1'b1; #1;
      n_checks++;
      if ({dp0_ready_o, dp1_ready_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL wrap_ready: rdy=%b%b, required 11", dp0_ready_o, dp1_ready_o);
      end
      // 32769 * 65534 = 0x7FFFFFFE in slot 0 for the first three elements.
      repeat (32769) begin
         @(posedge clk);
         model_cap(dp0_res_i, dp1_res_i, 1'b1, 1'b1, 0);
      end
      #1 dp0_valid_i = 1'b0; dp1_valid_i = 1'b0; add_enable_i = 1'b0;
      send0(pk(1, 1, 1, 1), 1'b1, 0);
      send0(pk(1, 1, 1, 1), 1'b0, 0);
      wait_done("wrap");
   endtask

   task automatic test_drain();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected words never emitted, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_emit();
      test_accumulate();
      test_add_mode();
      test_arbitration();
      test_backpressure();
      test_clear_mid_emit();
      test_reset_mid_emit();
      test_wrap();
      test_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
